// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// The result is computed when the instruction issues and parked in a pending
// register; the FSM then stalls the pipeline for a fixed latency (5 cycles for
// multiply, 10 for divide) before committing the pending value to HI/LO.
// Optional feature: define MD_MADD_EN to enable madd/maddu (ops 4/5) and the
// 64-bit accumulate adder; without it ops 4/5 are reserved and ignored.
module md_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        cancel,
    output logic        busy,
    output logic        state_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q;

    logic        op_valid_s;
    logic        is_div_s;
    logic        is_signed_s;
    logic        is_acc_s;
    logic [3:0]  n_s;
    logic        start_ok_s;

    logic [63:0] mul_a_s, mul_b_s, product_s;
    logic        dvd_neg_s, dvs_neg_s;
    logic [31:0] div_a_s, div_b_s, div_den_s;
    logic [31:0] quo_mag_s, rem_mag_s, quo_s, rem_s;
    logic [63:0] result_s;

    // Decode the issuing op into class flags; reserved ops stay invalid.
    always_comb begin
        op_valid_s  = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        is_acc_s    = 1'b0;
        case (op)
            3'd0: begin
                op_valid_s  = 1'b1;
                is_signed_s = 1'b1;
            end
            3'd1: begin
                op_valid_s  = 1'b1;
            end
            3'd2: begin
                op_valid_s  = 1'b1;
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            3'd3: begin
                op_valid_s  = 1'b1;
                is_div_s    = 1'b1;
            end
`ifdef MD_MADD_EN
            3'd4: begin
                op_valid_s  = 1'b1;
                is_signed_s = 1'b1;
                is_acc_s    = 1'b1;
            end
            3'd5: begin
                op_valid_s  = 1'b1;
                is_acc_s    = 1'b1;
            end
`endif
            default: begin
                op_valid_s  = 1'b0;
                is_div_s    = 1'b0;
                is_signed_s = 1'b0;
                is_acc_s    = 1'b0;
            end
        endcase
    end

    assign n_s        = is_div_s ? 4'd10 : 4'd5;
    assign start_ok_s = start & ~cancel & op_valid_s;

    // One 64x64 multiplier serves both signednesses via operand extension;
    // the low 64 bits of the extended product are the exact 32x32 product.
    assign mul_a_s   = is_signed_s ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    assign mul_b_s   = is_signed_s ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    assign product_s = mul_a_s * mul_b_s;

    // Signed divide runs on magnitudes through a single unsigned divider.
    // This makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0 naturally.
    assign dvd_neg_s = is_signed_s & rs_val[31];
    assign dvs_neg_s = is_signed_s & rt_val[31];
    assign div_a_s   = dvd_neg_s ? (32'd0 - rs_val) : rs_val;
    assign div_b_s   = dvs_neg_s ? (32'd0 - rt_val) : rt_val;
    assign div_den_s = (div_b_s == 32'd0) ? 32'd1 : div_b_s;
    assign quo_mag_s = div_a_s / div_den_s;
    assign rem_mag_s = div_a_s % div_den_s;
    assign quo_s     = (dvd_neg_s ^ dvs_neg_s) ? (32'd0 - quo_mag_s) : quo_mag_s;
    assign rem_s     = dvd_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;

    // Select the value to commit at the end of the run; divide by zero
    // re-commits the current HI/LO so the registers are left unchanged.
    always_comb begin
        result_s = product_s;
        if (is_div_s) begin
            if (rt_val == 32'd0) begin
                result_s = {hi_q, lo_q};
            end else begin
                result_s = {rem_s, quo_s};
            end
        end else begin
`ifdef MD_MADD_EN
            if (is_acc_s) begin
                result_s = {hi_q, lo_q} + product_s;
            end else begin
                result_s = product_s;
            end
`else
            if (is_acc_s) begin
                result_s = product_s;
            end else begin
                result_s = product_s;
            end
`endif
        end
    end

    // Next-state logic: issue, latency countdown, commit and HI/LO moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    cnt_d   = n_s;
                    pend_d  = result_s;
                end else if (!cancel && !start) begin
                    // An asserted start (even one that is ignored) wins over moves.
                    if (mthi) begin
                        hi_d = rs_val;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo) begin
                        lo_d = rs_val;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q <= 4'd1) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == ST_RUN);
        end
    end

    assign busy     = busy_q;
    assign state_md = start | busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer.
module tb_md_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic        cancel;
    logic        busy;
    logic        state_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    md_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .cancel   (cancel),
        .busy     (busy),
        .state_md (state_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle; returns in cycle T+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
    endtask

    // Count consecutive busy cycles (bounded); returns in the first non-busy cycle.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || state_md !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b hi=%h lo=%h state_md=%b, required 0/0/0/0", busy, hi, lo, state_md);
        end
        start = 1'b1;
        op    = 3'd6;
        #1;
        checks++;
        if (state_md !== 1'b1) begin
            failures++;
            $display("FAIL state_md_follows_start: got %b, required 1", state_md);
        end
        start = 1'b0;
        #1;
        tick();
    endtask

    task automatic test_mult();
        int n;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        count_busy(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL mult_latency: busy cycles=%0d, required 5", n);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            failures++;
            $display("FAIL mult_result: hi=%h lo=%h, required ffffffff/fffffffa", hi, lo);
        end
        // back-to-back: next op issues in the very cycle busy has fallen
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            failures++;
            $display("FAIL multu_result: n=%0d hi=%h lo=%h, required 5 fffffffe/00000001", n, hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        issue(3'd3, 32'd100, 32'd7);
        count_busy(n);
        checks++;
        if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
            failures++;
            $display("FAIL divu_100_7: n=%0d hi=%h lo=%h, required 10 2/14", n, hi, lo);
        end
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_m7_2: n=%0d hi=%h lo=%h, required 10 ffffffff/fffffffd", n, hi, lo);
        end
        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        count_busy(n);
        checks++;
        if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_7_m2: hi=%h lo=%h, required 00000001/fffffffd", hi, lo);
        end
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            failures++;
            $display("FAIL div_overflow: hi=%h lo=%h, required 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        int n;
        mthi   = 1'b1;
        mtlo   = 1'b1;
        rs_val = 32'h1234;
        tick();
        mtlo   = 1'b0;
        rs_val = 32'h5678;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h1234) begin
            failures++;
            $display("FAIL move_both: hi=%h lo=%h, required 00001234/00001234", hi, lo);
        end
        mthi = 1'b0;
        mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            failures++;
            $display("FAIL move_lo_only: hi=%h lo=%h, required 00001234/00005678", hi, lo);
        end
        issue(3'd2, 32'd5, 32'd0);
        count_busy(n);
        checks++;
        if (n !== 10 || hi !== 32'h1234 || lo !== 32'h5678) begin
            failures++;
            $display("FAIL div_by_zero: n=%0d hi=%h lo=%h, required 10 00001234/00005678", n, hi, lo);
        end
    endtask

    task automatic test_cancel();
        int n;
        cancel = 1'b1;
        issue(3'd0, 32'd2, 32'd3);
        checks++;
        if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            failures++;
            $display("FAIL cancel_start: busy=%b hi=%h lo=%h, required 0 00001234/00005678", busy, hi, lo);
        end
        mthi   = 1'b1;
        rs_val = 32'hBEEF;
        tick();
        mthi   = 1'b0;
        cancel = 1'b0;
        checks++;
        if (hi !== 32'h1234) begin
            failures++;
            $display("FAIL cancel_mthi: hi=%h, required 00001234", hi);
        end
        // cancel and mthi during RUN must not disturb the operation
        issue(3'd0, 32'd2, 32'd3);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        mthi   = 1'b1;
        rs_val = 32'hAAAA;
        tick();
        mthi   = 1'b0;
        checks++;
        if (hi !== 32'h1234 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mthi_in_run: hi=%h busy=%b, required 00001234 1", hi, busy);
        end
        count_busy(n);
        checks++;
        if (n !== 3 || hi !== 32'd0 || lo !== 32'd6) begin
            failures++;
            $display("FAIL cancel_in_run: remaining=%0d hi=%h lo=%h, required 3 0/6", n, hi, lo);
        end
    endtask

    task automatic test_reserved();
        for (int k = 6; k <= 7; k++) begin
            issue(3'(k), 32'd9, 32'd9);
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
                failures++;
                $display("FAIL reserved_op%0d: busy=%b hi=%h lo=%h, required 0 0/6", k, busy, hi, lo);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || state_md !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h state_md=%b, required 0 0/0 0", busy, hi, lo, state_md);
        end
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_discard: hi=%h lo=%h, required 0/0", hi, lo);
        end
    endtask

    task automatic test_madd();
        int n;
        mtlo   = 1'b1;
        rs_val = 32'hFFFFFFFF;
        tick();
        mtlo   = 1'b0;
        issue(3'd5, 32'd1, 32'd1);
        count_busy(n);
`ifdef MD_MADD_EN
        checks++;
        if (n !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
            failures++;
            $display("FAIL maddu: n=%0d hi=%h lo=%h, required 5 1/0", n, hi, lo);
        end
        issue(3'd4, 32'hFFFFFFFF, 32'd1);
        count_busy(n);
        checks++;
        if (n !== 5 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL madd: n=%0d hi=%h lo=%h, required 5 0/ffffffff", n, hi, lo);
        end
`else
        checks++;
        if (n !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL maddu_disabled: n=%0d hi=%h lo=%h, required 0 0/ffffffff", n, hi, lo);
        end
`endif
    endtask

    // Hard watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        cancel   = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_reserved();
        test_reset_mid_run();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 The block SHALL have ports: reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-003 The block SHALL have ports: start  in  1  E-stage mult/div instruction issues this cycle.
REQ-004 The block SHALL have ports: op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6/7 reserved.
REQ-005 The block SHALL have ports: rs_val, rt_val  in  32 each  forwarded E-stage operands.
REQ-006 The block SHALL have ports: mthi, mtlo  in  1 each  move-to HI/LO this cycle, data on rs_val.
REQ-007 The block SHALL have ports: cancel  in  1  exception/interrupt flush of E-stage instruction this cycle.
REQ-008 The block SHALL have ports: busy  out  1  operation in flight.
REQ-009 The block SHALL have ports: state_md  out  1  start OR busy, combinational, consumed by stall control.
REQ-010 The block SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 In IDLE, start=1 with cancel=0 and a valid op SHALL latch the op, compute the result into a pending register, load the 4-bit counter with N, and enter RUN.
REQ-013 N SHALL be 5 for mult/multu/madd/maddu and 10 for div/divu.
REQ-014 In RUN, the counter SHALL decrement each cycle. busy SHALL be 1 throughout RUN.
REQ-015 When the counter reaches 1, the FSM SHALL write the pending result to HI/LO and return to IDLE; busy falls on the next cycle.
REQ-016 Timing: for start in cycle T, busy=1 in cycles T+1..T+N and busy=0 at T+N+1, with new HI/LO visible at T+N+1.
REQ-017 mult: {hi,lo} = signed 64-bit product.
REQ-018 multu: {hi,lo} = unsigned 64-bit product.
REQ-019 div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-020 divu: same as div, unsigned.
REQ-021 madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned), modulo 2^64, using HI/LO as sampled at start.
REQ-022 Divide with rt_val=0 SHALL still run N cycles and leave HI/LO unchanged.
REQ-023 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 start while in RUN SHALL be ignored; stall control guarantees this never occurs.
REQ-025 start with a reserved op SHALL be ignored: no state change, busy stays 0.
REQ-026 cancel=1 SHALL suppress start, mthi and mtlo in the same cycle.
REQ-027 cancel SHALL NOT abort an operation already in RUN.
REQ-028 mthi/mtlo in IDLE SHALL write rs_val to hi/lo at the clock edge.
REQ-029 mthi/mtlo in RUN SHALL be ignored.
REQ-030 If mthi and mtlo are both asserted in IDLE, both registers SHALL be written.
REQ-031 If start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL take priority and the move SHALL be dropped.

Reset
REQ-032 On reset=1 at a clock edge: state IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0.
REQ-033 Reset during RUN SHALL discard the in-flight result; HI/LO become 0, not the pending value.
REQ-034 state_md SHALL equal start after reset, since busy=0.

Configuration
REQ-035 The macro MD_MADD_EN SHALL control madd/maddu support.
REQ-036 With MD_MADD_EN defined, op 4/5 SHALL execute per REQ-021.
REQ-037 Without MD_MADD_EN, op 4/5 SHALL be treated as reserved per REQ-025, and the accumulate adder SHALL be absent.

Verification
REQ-038 Scenario: reset, then mult with rs=0xFFFFFFFE(-2), rt=3 at T. Required: busy=1 for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 Scenario: divu with rs=100, rt=7. Required: busy for 10 cycles; then lo=14, hi=2. Signed div -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 Scenario: mthi 0x1234 and mtlo 0x5678, then div by 0. Required: after 10 busy cycles hi=0x1234, lo=0x5678.
REQ-041 Scenario: start with cancel=1. Required: busy stays 0, HI/LO unchanged. Also, mthi 0xAAAA during RUN: hi unchanged.
REQ-042 Scenario: reset asserted in the 3rd cycle of a mult. Required: next cycle busy=0, hi=lo=0, state_md=0.
REQ-043 Scenario (MD_MADD_EN defined): hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1. Required: hi=1, lo=0. With the macro undefined, the same stimulus gives no busy and no change.
